ps2_host_tx: RTL
================

Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte (LED set, reset, typematic rate, …) from the FPGA to the keyboard.
- Sits beside the PS/2 keyboard receiver on the same kbd_clk/kbd_dat pair and drives the lines open-drain through external tristate buffers (oe=1 pulls the line low).
- Performs inhibit and request-to-send, shifts out data on device-generated clock edges, checks the device ACK, and reports done or error.

Parameters:
- INHIBIT_CYCLES, 5000: cycles kbd_clk is held low before request-to-send (100 us at 50 MHz).
- REQ_CYCLES, 50: cycles kbd_dat and kbd_clk are both held low before kbd_clk is released.
- TIMEOUT_CYCLES, 750000: maximum cycles from kbd_clk release to line-idle (15 ms at 50 MHz).

Ports:
- clk, in, 1: system clock.
- resetN, in, 1: synchronous active-low reset.
- din, in, 8: command byte.
- din_valid, in, 1: start request; sampled only when ready=1.
- ready, out, 1: high in IDLE only.
- kbd_clk, in, 1: raw PS/2 clock line (asynchronous).
- kbd_dat, in, 1: raw PS/2 data line (asynchronous).
- kbd_clk_oe, out, 1: 1 = pull PS/2 clock low.
- kbd_dat_oe, out, 1: 1 = pull PS/2 data low.
- done, out, 1: one-cycle pulse, frame sent and ACK received.
- error, out, 1: one-cycle pulse, timeout or missing ACK.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on resetN. With resetN=0 at a rising clk edge, in every state including mid-frame:
  - state goes to IDLE, all counters clear, lines released (kbd_clk_oe=0, kbd_dat_oe=0);
  - done=0, error=0, ready=1 from the following cycle.
- Input sampling: kbd_clk and kbd_dat each pass through a 2-flop synchronizer (clk_s, dat_s).
  - fall = clk_s_prev & ~clk_s; single-cycle strobe. Edge detection adds 3 cycles latency from the pin.
- Transmit bits:
  - din is latched into tx_byte on acceptance.
  - parity = ~^tx_byte (odd parity).
  - Frame bit index b = 0..9: b0..b7 = tx_byte LSB first, b8 = parity, b9 = stop (=1).
  - Drive rule: kbd_dat_oe = ~bit. A bit value of 1 is sent as released.
- States:
  - IDLE: ready=1, lines released. If din_valid=1, latch din and go to INHIBIT, counter=0. din_valid in any other state is ignored.
  - INHIBIT: kbd_clk_oe=1, kbd_dat_oe=0. After INHIBIT_CYCLES cycles go to REQ.
  - REQ: kbd_clk_oe=1, kbd_dat_oe=1 (start bit). After REQ_CYCLES cycles go to SHIFT with b=0, and start the timeout counter.
  - SHIFT: kbd_clk_oe=0; kbd_dat_oe holds the current value (the start bit, low, until the first fall). On each fall, drive frame bit b and increment b. The fall that drives b9 (the 10th fall) moves the state to ACK.
  - ACK: stop bit released. On the next fall (the 11th): dat_s=0 goes to WAIT_IDLE; dat_s=1 asserts error and goes to IDLE.
  - WAIT_IDLE: when clk_s=1 and dat_s=1, assert done and go to IDLE.
- Timeout:
  - Applies in SHIFT, ACK and WAIT_IDLE. The counter reaching TIMEOUT_CYCLES-1 releases both lines, pulses error, and returns to IDLE.
  - Timeout has priority over a fall in the same cycle.
- Pulse and state rules:
  - done and error are mutually exclusive and last exactly one cycle.
  - ready returns to 1 the cycle after either pulse.
  - No new request is accepted in the same cycle as done or error.
- Receiver interaction: while the block holds kbd_clk low, the receiver sees a frame aborted by the host. The device retransmits afterwards; this block takes no action.
- Counters: timeout counter ceil(log2(TIMEOUT_CYCLES)) bits and saturating; bit counter 4 bits.

Test Plan:
(Bench parameters: INHIBIT_CYCLES=20, REQ_CYCLES=4, TIMEOUT_CYCLES=2000. Device model generates a 40-cycle-period clock after kbd_clk release.)
- din=0xED with din_valid → kbd_clk_oe high for 20 cycles, then dat+clk low for 4 cycles. Device samples on rising edges: start 0, data 1,0,1,1,0,1,1,1, parity 1, stop 1. Device ACKs low → single done pulse, error never high.
- din=0x07 → data bits 1,1,1,0,0,0,0,0, parity 0. din=0x00 → parity 1. Both end with done.
- Device gives the 11th clock without pulling data low → error pulse one cycle after that fall, no done, lines released.
- Device never clocks after release → error at exactly 2000 cycles after entering SHIFT, kbd_dat_oe=0.
- din_valid pulsed while busy (ready=0) with din=0xFF → ignored; the frame in flight still sends the originally latched byte.
- resetN=0 asserted after bit 4 → next cycle both oe=0, ready=1, no done or error. A new request then sends a clean full frame.

Source files
------------

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command transmitter.
// Inhibits the bus, issues request-to-send, shifts one byte plus odd parity
// and stop bit out on device clock falls, checks the device ACK and reports
// completion with a one-cycle done or error pulse. The PS/2 lines are driven
// open-drain through external buffers: an *_oe of 1 pulls that line low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int REQ_CYCLES     = 50,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic       ready,
    input  logic       kbd_clk,
    input  logic       kbd_dat,
    output logic       kbd_clk_oe,
    output logic       kbd_dat_oe,
    output logic       done,
    output logic       error
);

    // Inhibit and request phases share one delay counter sized for the longer.
    localparam int DLY_MAX = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
    localparam int DLY_W   = $clog2(DLY_MAX + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);

    localparam logic [DLY_W-1:0] INH_LAST = DLY_W'(INHIBIT_CYCLES - 1);
    localparam logic [DLY_W-1:0] REQ_LAST = DLY_W'(REQ_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_MAX  = {TMO_W{1'b1}};
    localparam logic [3:0]       STOP_IDX = 4'd9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    // Odd parity over the command byte: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    // Frame bit for index 0..9: data LSB first, then parity, then stop (1).
    function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
        logic bit_v;
        if (idx < 4'd8) begin
            bit_v = b[idx[2:0]];
        end else if (idx == 4'd8) begin
            bit_v = odd_parity(b);
        end else begin
            bit_v = 1'b1;
        end
        return bit_v;
    endfunction

    // Synchronizers for the asynchronous PS/2 lines (idle level is high).
    logic clk_meta_r;
    logic clk_s;
    logic clk_s_prev;
    logic dat_meta_r;
    logic dat_s;
    logic fall_s;

    // Main state and counters.
    state_t           state_r;
    logic [DLY_W-1:0] dly_cnt_r;
    logic [TMO_W-1:0] tmo_cnt_r;
    logic [3:0]       bit_cnt_r;
    logic [7:0]       tx_byte_r;

    // Registered outputs.
    logic ready_r;
    logic clk_oe_r;
    logic dat_oe_r;
    logic done_r;
    logic error_r;

    // Next-state values.
    state_t           state_next_s;
    logic [DLY_W-1:0] dly_next_s;
    logic [TMO_W-1:0] tmo_next_s;
    logic [TMO_W-1:0] tmo_inc_s;
    logic             tmo_hit_s;
    logic [3:0]       bit_next_s;
    logic [7:0]       byte_next_s;
    logic             ready_next_s;
    logic             clk_oe_next_s;
    logic             dat_oe_next_s;
    logic             done_next_s;
    logic             error_next_s;

    // Two-flop synchronizers plus one delay stage on the clock for edge detection.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            clk_meta_r <= 1'b1;
            clk_s      <= 1'b1;
            clk_s_prev <= 1'b1;
            dat_meta_r <= 1'b1;
            dat_s      <= 1'b1;
        end else begin
            clk_meta_r <= kbd_clk;
            clk_s      <= clk_meta_r;
            clk_s_prev <= clk_s;
            dat_meta_r <= kbd_dat;
            dat_s      <= dat_meta_r;
        end
    end

    // Single-cycle strobe on a falling edge of the synchronized device clock.
    assign fall_s = clk_s_prev & ~clk_s;

    // Saturating timeout increment and terminal-count detect.
    assign tmo_inc_s = (tmo_cnt_r == TMO_MAX) ? tmo_cnt_r : (tmo_cnt_r + TMO_W'(1));
    assign tmo_hit_s = (tmo_cnt_r == TMO_LAST);

    // Next-state and next-output logic for the transmit sequence.
    always_comb begin
        state_next_s  = state_r;
        dly_next_s    = dly_cnt_r;
        tmo_next_s    = tmo_cnt_r;
        bit_next_s    = bit_cnt_r;
        byte_next_s   = tx_byte_r;
        clk_oe_next_s = clk_oe_r;
        dat_oe_next_s = dat_oe_r;
        ready_next_s  = 1'b0;
        done_next_s   = 1'b0;
        error_next_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                clk_oe_next_s = 1'b0;
                dat_oe_next_s = 1'b0;
                dly_next_s    = '0;
                tmo_next_s    = '0;
                bit_next_s    = 4'd0;
                // ready_r is low in the pulse cycle, so a request cannot start then.
                if (ready_r && din_valid) begin
                    byte_next_s   = din;
                    state_next_s  = ST_INHIBIT;
                    clk_oe_next_s = 1'b1;
                end else begin
                    ready_next_s = 1'b1;
                end
            end

            ST_INHIBIT: begin
                clk_oe_next_s = 1'b1;
                dat_oe_next_s = 1'b0;
                if (dly_cnt_r == INH_LAST) begin
                    state_next_s  = ST_REQ;
                    dly_next_s    = '0;
                    dat_oe_next_s = 1'b1;
                end else begin
                    dly_next_s = dly_cnt_r + DLY_W'(1);
                end
            end

            ST_REQ: begin
                dat_oe_next_s = 1'b1;
                if (dly_cnt_r == REQ_LAST) begin
                    // Release the clock; the start bit stays driven low.
                    state_next_s  = ST_SHIFT;
                    dly_next_s    = '0;
                    tmo_next_s    = '0;
                    bit_next_s    = 4'd0;
                    clk_oe_next_s = 1'b0;
                end else begin
                    dly_next_s    = dly_cnt_r + DLY_W'(1);
                    clk_oe_next_s = 1'b1;
                end
            end

            ST_SHIFT: begin
                clk_oe_next_s = 1'b0;
                if (tmo_hit_s) begin
                    state_next_s  = ST_IDLE;
                    dat_oe_next_s = 1'b0;
                    tmo_next_s    = '0;
                    bit_next_s    = 4'd0;
                    error_next_s  = 1'b1;
                end else if (fall_s) begin
                    tmo_next_s    = tmo_inc_s;
                    dat_oe_next_s = ~frame_bit(tx_byte_r, bit_cnt_r);
                    bit_next_s    = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == STOP_IDX) begin
                        state_next_s = ST_ACK;
                    end else begin
                        state_next_s = ST_SHIFT;
                    end
                end else begin
                    tmo_next_s = tmo_inc_s;
                end
            end

            ST_ACK: begin
                clk_oe_next_s = 1'b0;
                dat_oe_next_s = 1'b0;
                if (tmo_hit_s) begin
                    state_next_s = ST_IDLE;
                    tmo_next_s   = '0;
                    bit_next_s   = 4'd0;
                    error_next_s = 1'b1;
                end else if (fall_s) begin
                    tmo_next_s = tmo_inc_s;
                    if (dat_s) begin
                        // Device did not pull data low on the ACK clock.
                        state_next_s = ST_IDLE;
                        tmo_next_s   = '0;
                        bit_next_s   = 4'd0;
                        error_next_s = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT_IDLE;
                    end
                end else begin
                    tmo_next_s = tmo_inc_s;
                end
            end

            ST_WAIT_IDLE: begin
                clk_oe_next_s = 1'b0;
                dat_oe_next_s = 1'b0;
                if (tmo_hit_s) begin
                    state_next_s = ST_IDLE;
                    tmo_next_s   = '0;
                    bit_next_s   = 4'd0;
                    error_next_s = 1'b1;
                end else if (clk_s && dat_s) begin
                    state_next_s = ST_IDLE;
                    tmo_next_s   = '0;
                    bit_next_s   = 4'd0;
                    done_next_s  = 1'b1;
                end else begin
                    tmo_next_s = tmo_inc_s;
                end
            end

            default: begin
                state_next_s  = ST_IDLE;
                clk_oe_next_s = 1'b0;
                dat_oe_next_s = 1'b0;
                dly_next_s    = '0;
                tmo_next_s    = '0;
                bit_next_s    = 4'd0;
            end
        endcase
    end

    // State, counter and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_r   <= ST_IDLE;
            dly_cnt_r <= '0;
            tmo_cnt_r <= '0;
            bit_cnt_r <= 4'd0;
            tx_byte_r <= 8'h00;
            ready_r   <= 1'b1;
            clk_oe_r  <= 1'b0;
            dat_oe_r  <= 1'b0;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            dly_cnt_r <= dly_next_s;
            tmo_cnt_r <= tmo_next_s;
            bit_cnt_r <= bit_next_s;
            tx_byte_r <= byte_next_s;
            ready_r   <= ready_next_s;
            clk_oe_r  <= clk_oe_next_s;
            dat_oe_r  <= dat_oe_next_s;
            done_r    <= done_next_s;
            error_r   <= error_next_s;
        end
    end

    assign ready      = ready_r;
    assign kbd_clk_oe = clk_oe_r;
    assign kbd_dat_oe = dat_oe_r;
    assign done       = done_r;
    assign error      = error_r;

endmodule
